// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit:
// FSM states, opcodes, ALU codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps ALUOp, funct3, op[5], funct7b5 to ALUControl.
// Ports: aluop, funct3, op5, funct7b5 in; ALUControl out.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // Only R-type distinguishes sub; addi never subtracts.
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control: Moore FSM driving datapath selects
// and enables, plus retired-instruction counter and illegal-op flag.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic [1:0]       ImmSrc,
    output logic [CNT_W-1:0] InstRet,
    output logic             IllegalInstr
);

    state_t     state;
    state_t     next;
    logic       pcupdate;
    logic       branch;
    logic [1:0] aluop;
    logic       retire;
    logic       illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_FETCH;
            InstRet      <= '0;
            IllegalInstr <= 1'b0;
        end else begin
            state <= next;
            if (retire)
                InstRet <= InstRet + CNT_W'(1);
            if (illegal)
                IllegalInstr <= 1'b1;
        end
    end

    always_comb begin
        next      = S_FETCH;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        aluop     = ALUOP_ADD;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                pcupdate  = 1'b1;
                next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXECUTER;
                    OP_IALU:      next = S_EXECUTEI;
                    OP_BEQ:       next = S_BEQ;
                    OP_JAL:       next = S_JAL;
                    default: begin
                        next    = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                next   = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_FUNC;
                next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNC;
                next    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcupdate = 1'b1;
                next     = S_ALUWB;
            end
            default: next = S_FETCH;
        endcase
    end

    assign PCWrite = pcupdate | (branch & Zero);

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule
